// File: rtl/daq_rate_pkg.sv
// Shared definitions for the DAQ link rate-switch controller:
// state encoding, default per-rate table entries and a clog2 helper.
package daq_rate_pkg;

   typedef enum logic [2:0] {
      ST_LOCKED = 3'd0,
      ST_REFCLK = 3'd1,
      ST_WRDCLK = 3'd2,
      ST_RSTCDV = 3'd3,
      ST_RSTPCS = 3'd4,
      ST_FAULT  = 3'd5
   } dqrt_state_e;

   // Rate 0 is 3.2 Gb/s, rate 1 is 1.25 Gb/s in the default tables
   localparam logic [2:0] CLK_SEL_3G2   = 3'b001;
   localparam logic [2:0] CLK_SEL_1G25  = 3'b000;
   localparam logic [1:0] RATE_SEL_3G2  = 2'b11;
   localparam logic [1:0] RATE_SEL_1G25 = 2'b10;
   localparam logic       WRDCLK_3G2    = 1'b1;
   localparam logic       WRDCLK_1G25   = 1'b0;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      if (r < 1) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/daq_rate_switch_ctrl.sv
// Rate-switch sequencer: refclk change, word-clock change, clock-divider reset,
// PCS reset, with timeout-protected waits and automatic retry.
module daq_rate_switch_ctrl
   import daq_rate_pkg::*;
#(
   parameter int                    NRATES       = 2,
   parameter int                    RW           = clog2(NRATES),
   parameter int                    RST_RATE     = 0,
   parameter logic [NRATES*3-1:0]   CLK_SEL_TBL  = {CLK_SEL_1G25, CLK_SEL_3G2},
   parameter logic [NRATES*2-1:0]   RATE_SEL_TBL = {RATE_SEL_1G25, RATE_SEL_3G2},
   parameter logic [NRATES-1:0]     WRDCLK_TBL   = {WRDCLK_1G25, WRDCLK_3G2},
   parameter int                    WRD_CYC      = 6,
   parameter int                    PCS_CYC      = 6,
   parameter int                    TIMEOUT_CYC  = 1023
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [RW-1:0]     RATE_REQ,
   input  logic              TXRATEDONE,
   input  logic              CDV_DONE,
   output logic [2:0]        CLK_SEL,
   output logic [1:0]        RATE_SEL,
   output logic              WRDCLKSEL,
   output logic              CDV_INIT,
   output logic              PCSRST,
   output logic [NRATES-1:0] RATE_ACTIVE,
   output logic [RW-1:0]     CUR_RATE,
   output logic              BUSY,
   output logic              BAD_REQ,
   output logic              ERR,
   output logic [7:0]        ERR_CNT,
   output logic [2:0]        DQRT_STATE
);

   localparam int MAX_AB = (WRD_CYC > PCS_CYC) ? WRD_CYC : PCS_CYC;
   localparam int MAXC   = (MAX_AB > TIMEOUT_CYC) ? MAX_AB : TIMEOUT_CYC;
   localparam int CW     = clog2(MAXC + 1);

   localparam logic [CW-1:0] WRD_LAST = CW'(WRD_CYC - 1);
   localparam logic [CW-1:0] PCS_LAST = CW'(PCS_CYC - 1);
   localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
   localparam logic [RW-1:0] RST_IDX  = RW'(RST_RATE);

   // Table lookups use constant part-selects so out-of-range indices read as zero
   function automatic logic [2:0] clk_sel_of(input logic [RW-1:0] idx);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < NRATES; i++)
         if (idx == RW'(i)) r = CLK_SEL_TBL[3*i +: 3];
      return r;
   endfunction

   function automatic logic [1:0] rate_sel_of(input logic [RW-1:0] idx);
      logic [1:0] r;
      r = '0;
      for (int i = 0; i < NRATES; i++)
         if (idx == RW'(i)) r = RATE_SEL_TBL[2*i +: 2];
      return r;
   endfunction

   function automatic logic wrdclk_of(input logic [RW-1:0] idx);
      logic r;
      r = 1'b0;
      for (int i = 0; i < NRATES; i++)
         if (idx == RW'(i)) r = WRDCLK_TBL[i];
      return r;
   endfunction

   function automatic logic [NRATES-1:0] onehot_of(input logic [RW-1:0] idx);
      logic [NRATES-1:0] r;
      r = '0;
      for (int i = 0; i < NRATES; i++)
         r[i] = (idx == RW'(i));
      return r;
   endfunction

   dqrt_state_e    state, state_nxt;
   logic [RW-1:0]  cur_rate, cur_nxt, target, target_nxt;
   logic [CW-1:0]  cnt, cnt_nxt;
   logic           bad_nxt, err_nxt;
   logic [RW-1:0]  sel_idx, wrd_idx;

   always_comb begin
      state_nxt  = state;
      target_nxt = target;
      cur_nxt    = cur_rate;
      bad_nxt    = 1'b0;
      err_nxt    = 1'b0;
      case (state)
         ST_LOCKED: begin
            if (onehot_of(RATE_REQ) == '0) begin
               bad_nxt = 1'b1;
            end else if (RATE_REQ != cur_rate) begin
               target_nxt = RATE_REQ;
               state_nxt  = ST_REFCLK;
            end
         end
         ST_REFCLK: begin
            if (TXRATEDONE) begin
               state_nxt = ST_WRDCLK;
            end else if (cnt == TO_LAST) begin
               state_nxt = ST_FAULT;
               err_nxt   = 1'b1;
            end
         end
         ST_WRDCLK: if (cnt == WRD_LAST) state_nxt = ST_RSTCDV;
         ST_RSTCDV: begin
            if (CDV_DONE) begin
               state_nxt = ST_RSTPCS;
            end else if (cnt == TO_LAST) begin
               state_nxt = ST_FAULT;
               err_nxt   = 1'b1;
            end
         end
         ST_RSTPCS: begin
            if (cnt == PCS_LAST) begin
               state_nxt = ST_LOCKED;
               cur_nxt   = target;
            end
         end
         ST_FAULT:  state_nxt = ST_REFCLK;
         default:   state_nxt = ST_LOCKED;
      endcase

      cnt_nxt = (state_nxt != state || state == ST_LOCKED) ? '0 : cnt + 1'b1;

      // Selects follow the target once its state has been entered, else CUR_RATE
      sel_idx = (state_nxt == ST_LOCKED) ? cur_nxt : target_nxt;
      wrd_idx = (state_nxt == ST_WRDCLK || state_nxt == ST_RSTCDV ||
                 state_nxt == ST_RSTPCS) ? target_nxt : cur_nxt;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= ST_LOCKED;
         cur_rate    <= RST_IDX;
         target      <= RST_IDX;
         cnt         <= '0;
         CLK_SEL     <= clk_sel_of(RST_IDX);
         RATE_SEL    <= rate_sel_of(RST_IDX);
         WRDCLKSEL   <= wrdclk_of(RST_IDX);
         CDV_INIT    <= 1'b0;
         PCSRST      <= 1'b0;
         RATE_ACTIVE <= '0;
         BUSY        <= 1'b0;
         BAD_REQ     <= 1'b0;
         ERR         <= 1'b0;
         ERR_CNT     <= '0;
      end else begin
         state       <= state_nxt;
         cur_rate    <= cur_nxt;
         target      <= target_nxt;
         cnt         <= cnt_nxt;
         CLK_SEL     <= clk_sel_of(sel_idx);
         RATE_SEL    <= rate_sel_of(sel_idx);
         WRDCLKSEL   <= wrdclk_of(wrd_idx);
         CDV_INIT    <= (state_nxt == ST_REFCLK) || (state_nxt == ST_WRDCLK);
         PCSRST      <= (state_nxt == ST_RSTPCS);
         RATE_ACTIVE <= (state_nxt == ST_LOCKED) ? onehot_of(cur_nxt) : '0;
         BUSY        <= (state_nxt != ST_LOCKED);
         BAD_REQ     <= bad_nxt;
         ERR         <= err_nxt;
         if (err_nxt && ERR_CNT != 8'hFF) ERR_CNT <= ERR_CNT + 8'd1;
      end
   end

   assign CUR_RATE   = cur_rate;
   assign DQRT_STATE = state;

endmodule

// File: doc/daq_rate_switch_ctrl.md
# daq_rate_switch_ctrl

Parametrised DAQ link rate-switch controller. It supports up to four selectable line rates, each described by per-rate lookup tables. Each switch runs a full sequence: reference-clock change, word-clock change, clock-divider reset, then PCS reset. Wait states are protected by timeouts with automatic retry. It sits between the DAQ rate request logic and the GTX transmitter/clock-divider controls, replacing the fixed two-rate sequencer.

## Interface
- NRATES, 2: number of supported rates, 2..4; RW = clog2(NRATES) (min 1).
- RST_RATE, 0: rate index locked after reset.
- CLK_SEL_TBL, {3'b000,3'b001}: packed NRATES×3; entry i = CLK_SEL for rate i (default rate0 = 3.2 Gb/s → 001, rate1 = 1.25 Gb/s → 000).
- RATE_SEL_TBL, {2'b10,2'b11}: packed NRATES×2 TX rate select per rate.
- WRDCLK_TBL, 2'b01: WRDCLKSEL per rate.
- WRD_CYC, 6: cycles spent in WRDCLK state (≥1).
- PCS_CYC, 6: cycles PCSRST is held (≥1).
- TIMEOUT_CYC, 1023: max cycles waiting for TXRATEDONE or CDV_DONE.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  reset; synchronous and active-high.
- RATE_REQ  in  RW  requested rate index.
- TXRATEDONE  in  1  transmitter rate change complete.
- CDV_DONE  in  1  clock-divider reset complete.
- CLK_SEL  out  3  reference clock select.
- RATE_SEL  out  2  TX rate select.
- WRDCLKSEL  out  1  word clock select.
- CDV_INIT  out  1  clock-divider init request.
- PCSRST  out  1  PCS reset.
- RATE_ACTIVE  out  NRATES  one-hot of locked rate; 0 while switching.
- CUR_RATE  out  RW  index of last locked (or current target) rate.
- BUSY  out  1  high in any state other than LOCKED.
- BAD_REQ  out  1  1-cycle pulse: RATE_REQ ≥ NRATES sampled in LOCKED.
- ERR  out  1  1-cycle pulse on each timeout.
- ERR_CNT  out  8  saturating timeout count.
- DQRT_STATE  out  3  state encoding, for debug.

## Operation
- States: LOCKED, REFCLK, WRDCLK, RSTCDV, RSTPCS, FAULT.
- LOCKED: RATE_ACTIVE is one-hot at CUR_RATE. If RATE_REQ < NRATES and RATE_REQ ≠ CUR_RATE, latch target = RATE_REQ and go to REFCLK. If RATE_REQ ≥ NRATES, pulse BAD_REQ and stay.
- REFCLK: CDV_INIT=1. CLK_SEL and RATE_SEL take the target table values. Wait for TXRATEDONE, then go to WRDCLK.
- WRDCLK: CDV_INIT=1. WRDCLKSEL takes the target value. Stay exactly WRD_CYC cycles, then go to RSTCDV.
- RSTCDV: CDV_INIT=0. Wait for CDV_DONE, then go to RSTPCS.
- RSTPCS: PCSRST=1 for exactly PCS_CYC cycles. Then go to LOCKED; CUR_RATE = target.
- Timeout: a wait counter clears on entry to REFCLK or RSTCDV. If the counter reaches TIMEOUT_CYC without the done signal, go to FAULT.
- FAULT: one cycle. ERR=1, ERR_CNT increments (saturates at 255), CDV_INIT=0. Then REFCLK is retried with the same target. The forced low cycle gives CDV_INIT a fresh rising edge.
- Done and timeout in the same cycle: done wins.
- RATE_REQ is ignored outside LOCKED. The target is fixed for the whole sequence; a new request is evaluated only after return to LOCKED.
- CLK_SEL, RATE_SEL and WRDCLKSEL hold their target values from entry to their respective states through LOCKED. In all other cases they follow the table entry for CUR_RATE.
- One shared cycle counter is used, wide enough for max(WRD_CYC, PCS_CYC, TIMEOUT_CYC). It clears on every state change.

## Timing
- All outputs are registered and decoded from nextstate, so they change on the same edge as the state register.
- Reset (synchronous): state=LOCKED, CUR_RATE=RST_RATE.
  - CLK_SEL, RATE_SEL and WRDCLKSEL take the table values for RST_RATE.
  - CDV_INIT=0, PCSRST=0, BAD_REQ=0, ERR=0, ERR_CNT=0, BUSY=0, all counters 0.
  - RATE_ACTIVE=0 during reset; it becomes one-hot of RST_RATE on the first edge after RST is released.
- Request sampled at edge t → state=REFCLK, BUSY=1, RATE_ACTIVE=0, CDV_INIT=1 from edge t.
- Minimum switch latency, with TXRATEDONE and CDV_DONE already high: 1 + WRD_CYC + 1 + PCS_CYC cycles from request to RATE_ACTIVE. This is 14 with the defaults.
- RST asserted mid-sequence aborts immediately to the reset values, including clearing ERR_CNT.

## Structure
- Shared package daq_rate_pkg holds:
  - state encoding constants (3-bit);
  - default table constants for the 3.2 and 1.25 Gb/s rates;
  - a clog2 function.
- No sub-module: one FSM with a shared counter; table lookup is an indexed part-select.

## Test plan
- Reset with defaults → CLK_SEL=001, RATE_SEL=11, WRDCLKSEL=1; RATE_ACTIVE=01 one cycle after release.
- RATE_REQ=1 with TXRATEDONE=CDV_DONE=1 → RATE_ACTIVE=10 exactly 14 cycles later.
  - CLK_SEL=000 and RATE_SEL=10 from the first cycle.
  - WRDCLKSEL=0 from the second cycle.
  - PCSRST high for exactly 6 cycles.
- TXRATEDONE held low, TIMEOUT_CYC=15 → ERR pulses after 15 REFCLK cycles; CDV_INIT drops for 1 cycle, then is reasserted.
  - After 300 such timeouts, ERR_CNT=255.
- NRATES=3, RATE_REQ=3 → BAD_REQ single pulse and no state change.
  - RATE_REQ toggled during WRDCLK has no effect until LOCKED.
- RST asserted in RSTPCS → next cycle PCSRST=0, state=LOCKED, CUR_RATE=RST_RATE, ERR_CNT=0.
- TXRATEDONE rising on the exact timeout cycle → transition to WRDCLK, no ERR pulse.
